axil_cmd_master: RTL and testbench
==================================

// Module: axil_cmd_master
// PURPOSE
//  AXI4-Lite initiator that turns single-beat commands from a simple valid/ready
//  command port into AXI-Lite write or read transactions, then returns response
//  and read data on a valid/ready response port. Drives the s_axil_* slave port of
//  the student register block for on-chip self-test and bring-up, without a host.
//  One outstanding transaction at a time. Counts error responses.
// PARAMETERS
//  ADDR_W  21  AXI-Lite address width; matches the register block slave port
//  DATA_W  32  AXI-Lite data width; STRB_W = DATA_W/8
//  PROT    3'b000  constant value driven on m_axil_awprot and m_axil_arprot
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous reset, active-high
//  cmd_valid      in   1       command present
//  cmd_ready      out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_we         in   1       1 = write, 0 = read
//  cmd_addr       in   ADDR_W  byte address
//  cmd_wdata      in   DATA_W  write data; ignored for reads
//  cmd_wstrb      in   STRB_W  write byte strobes; ignored for reads
//  rsp_valid      out  1       response present
//  rsp_ready      in   1       response consumed when rsp_valid&&rsp_ready
//  rsp_we         out  1       echo of cmd_we for this response
//  rsp_rdata      out  DATA_W  read data; 0 for writes
//  rsp_resp       out  2       BRESP or RRESP captured from slave
//  busy           out  1       high in any state other than IDLE
//  err_count      out  16      count of non-OKAY responses, saturating at 16'hFFFF
//  m_axil_aw*     out  awvalid 1, awaddr ADDR_W, awprot 3; awready in 1
//  m_axil_w*      out  wvalid 1, wdata DATA_W, wstrb STRB_W; wready in 1
//  m_axil_b*      bready out 1; bvalid in 1, bresp in 2
//  m_axil_ar*     out  arvalid 1, araddr ADDR_W, arprot 3; arready in 1
//  m_axil_r*      rready out 1; rvalid in 1, rdata in DATA_W, rresp in 2
// BEHAVIOUR
//  Reset: all valid/ready outputs 0 except none; cmd_ready=0, rsp_valid=0, busy=0,
//   err_count=0, data/addr/resp outputs 0, state=IDLE. cmd_ready is registered; it
//   rises the first clock after rst deasserts.
//  FSM: IDLE -> WRITE | READ_A -> ... -> RESP -> IDLE.
//  IDLE: cmd_ready=1. On handshake, register addr/data/strb/we; cmd_ready drops next
//   cycle. Write -> WRITE with awvalid=wvalid=1 the next cycle. Read -> READ_A with arvalid=1.
//  WRITE: awvalid and wvalid are independent; each drops the cycle after its own
//   handshake, in either order or together. Addr/data are stable while valid. When both
//   are done -> WRITE_B with bready=1.
//  WRITE_B: on bvalid&&bready capture bresp, rdata=0, bready->0, go to RESP.
//  READ_A: arvalid held until arready; then -> READ_D with rready=1.
//  READ_D: on rvalid&&rready capture rdata/rresp, rready->0, go to RESP.
//  RESP: rsp_valid=1 with held payload until rsp_ready, then -> IDLE.
//   Minimum cycle count with an always-ready slave and sink: cmd handshake to
//   rsp_valid = 3 cycles for writes and for reads.
//  err_count increments by 1 on entry to RESP when the captured resp != 2'b00;
//   it holds at 16'hFFFF.
//  No timeouts: the FSM waits indefinitely on the slave. Valids are never withdrawn
//   before their handshake.
//  Reset mid-transaction: the FSM aborts and outputs return to reset values
//   immediately. The slave must share rst.
//  Back-to-back: the next cmd is accepted no earlier than the cycle after rsp
//   handshake.
// TESTING
//  T1 write 0x0000_00A5 to LEDS addr, strb 4'hF, slave always ready -> AW/W valid
//   same cycle, bready seen, rsp_resp=00, rsp_we=1, LED=8'hA5, err_count=0.
//  T2 read back LEDS addr -> arvalid then rready, rsp_rdata=0x0000_00A5, resp=00.
//  T3 write with awready delayed 3 cycles and wready immediate -> wvalid drops after
//   1 cycle, awvalid held 4 cycles with stable awaddr, one bvalid, one rsp.
//  T4 stub slave returns bresp=2'b10 then rresp=2'b11 -> rsp_resp matches,
//   err_count=2. Preload err_count to 16'hFFFF, inject an error -> stays 16'hFFFF.
//  T5 rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready=0,
//   no new AXI activity.
//  T6 assert rst while arvalid=1 -> arvalid/busy 0 asynchronously; after release
//   cmd_ready=1 next cycle and a fresh read completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: AXI4-Lite initiator driven by a single-beat command port.
// Each accepted command becomes one AXI-Lite write or read; the slave's response
// (and read data) comes back on the response port. One transaction in flight.
//
// Handshake rule used on every port (cmd, rsp, aw, w, b, ar, r): a transfer
// happens on the rising clk edge where valid && ready are both high; a valid,
// once raised, stays high with a stable payload until that edge.
module axil_cmd_master #(
  parameter int         ADDR_W = 21,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  // status
  output logic                busy,
  output logic [15:0]         err_count,
  output logic [2:0]          state_dbg,
  // AXI-Lite write address
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  // AXI-Lite write data
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  // AXI-Lite write response
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  input  logic [1:0]          m_axil_bresp,
  // AXI-Lite read address
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  // AXI-Lite read data
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WRITE_B = 3'd2,
    S_READ_A  = 3'd3,
    S_READ_D  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                cmd_rdy_q;
  logic                aw_done, w_done;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic [15:0]         err_cnt;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;

  assign cmd_fire = cmd_valid && cmd_rdy_q;
  assign aw_fire  = m_axil_awvalid && m_axil_awready;
  assign w_fire   = m_axil_wvalid && m_axil_wready;
  assign b_fire   = m_axil_bvalid && m_axil_bready;
  assign ar_fire  = m_axil_arvalid && m_axil_arready;
  assign r_fire   = m_axil_rvalid && m_axil_rready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: each state waits indefinitely for its own handshake(s).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_fire) state_nxt = cmd_we ? S_WRITE : S_READ_A;
      S_WRITE:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = S_WRITE_B;
      S_WRITE_B: if (b_fire) state_nxt = S_RESP;
      S_READ_A:  if (ar_fire) state_nxt = S_READ_D;
      S_READ_D:  if (r_fire) state_nxt = S_RESP;
      S_RESP:    if (rsp_fire) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Channel valids/readies decoded from the current state and per-channel done flags.
  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    rsp_valid      = 1'b0;
    case (state)
      S_WRITE: begin
        m_axil_awvalid = !aw_done;
        m_axil_wvalid  = !w_done;
      end
      S_WRITE_B: m_axil_bready  = 1'b1;
      S_READ_A:  m_axil_arvalid = 1'b1;
      S_READ_D:  m_axil_rready  = 1'b1;
      S_RESP:    rsp_valid      = 1'b1;
      default: ;
    endcase
  end

  // Command capture, channel completion flags, response capture, error counting.
  // cmd_ready is a flop so it only rises a clock after reset or after a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rdy_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_cnt   <= 16'h0000;
    end else begin
      cmd_rdy_q <= (state_nxt == S_IDLE);
      if (cmd_fire) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_WRITE) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (b_fire) begin
        rdata_q <= '0;
        resp_q  <= m_axil_bresp;
        if (m_axil_bresp != 2'b00 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (r_fire) begin
        rdata_q <= m_axil_rdata;
        resp_q  <= m_axil_rresp;
        if (m_axil_rresp != 2'b00 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign cmd_ready     = cmd_rdy_q;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;
  assign err_count     = err_cnt;
  assign rsp_we        = we_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = PROT;
  assign m_axil_arprot = PROT;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: behavioural AXI-Lite slave with programmable
// ready delays and response injection, plus a reference memory and expected
// response queue derived from command semantics.
module tb_axil_cmd_master;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] LEDS_ADDR = 21'h000004;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              busy;
  logic [15:0]       err_count;
  logic [2:0]        state_dbg;
  logic              m_axil_awvalid, m_axil_awready;
  logic [ADDR_W-1:0] m_axil_awaddr;
  logic [2:0]        m_axil_awprot;
  logic              m_axil_wvalid, m_axil_wready;
  logic [DATA_W-1:0] m_axil_wdata;
  logic [3:0]        m_axil_wstrb;
  logic              m_axil_bvalid, m_axil_bready;
  logic [1:0]        m_axil_bresp;
  logic              m_axil_arvalid, m_axil_arready;
  logic [ADDR_W-1:0] m_axil_araddr;
  logic [2:0]        m_axil_arprot;
  logic              m_axil_rvalid, m_axil_rready;
  logic [DATA_W-1:0] m_axil_rdata;
  logic [1:0]        m_axil_rresp;

  axil_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT(3'b000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count), .state_dbg(state_dbg),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
  );

  // ---------------- behavioural slave ----------------
  int         aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0] b_inj = 2'b00, r_inj = 2'b00;
  int         aw_wait, w_wait, ar_wait;
  logic       aw_got, w_got;
  logic [ADDR_W-1:0] aw_addr_l;
  logic [DATA_W-1:0] w_data_l;
  logic [3:0]        w_strb_l;
  logic [DATA_W-1:0] slv_mem [16];

  assign m_axil_awready = m_axil_awvalid && (aw_wait >= aw_delay);
  assign m_axil_wready  = m_axil_wvalid && (w_wait >= w_delay);
  assign m_axil_arready = m_axil_arvalid && (ar_wait >= ar_delay);

  initial for (int i = 0; i < 16; i++) slv_mem[i] = '0;

  // Slave: accepts AW and W independently, answers B once both are in, answers R after AR.
  always @(posedge clk or posedge rst) begin : slave
    logic aw_now, w_now;
    logic [ADDR_W-1:0] a_l;
    logic [DATA_W-1:0] d_l;
    logic [3:0] s_l;
    if (rst) begin
      m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
      m_axil_rvalid <= 1'b0; m_axil_rresp <= 2'b00; m_axil_rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
    end else begin
      aw_wait <= (m_axil_awvalid && !m_axil_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axil_wvalid && !m_axil_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axil_arvalid && !m_axil_arready) ? ar_wait + 1 : 0;
      aw_now = aw_got || (m_axil_awvalid && m_axil_awready);
      w_now  = w_got || (m_axil_wvalid && m_axil_wready);
      a_l = (m_axil_awvalid && m_axil_awready) ? m_axil_awaddr : aw_addr_l;
      d_l = (m_axil_wvalid && m_axil_wready) ? m_axil_wdata : w_data_l;
      s_l = (m_axil_wvalid && m_axil_wready) ? m_axil_wstrb : w_strb_l;
      aw_addr_l <= a_l; w_data_l <= d_l; w_strb_l <= s_l;
      if (aw_now && w_now && !m_axil_bvalid) begin
        for (int b = 0; b < 4; b++) if (s_l[b]) slv_mem[a_l[5:2]][8*b +: 8] <= d_l[8*b +: 8];
        m_axil_bvalid <= 1'b1; m_axil_bresp <= b_inj;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      if (m_axil_arvalid && m_axil_arready) begin
        m_axil_rvalid <= 1'b1; m_axil_rdata <= slv_mem[m_axil_araddr[5:2]]; m_axil_rresp <= r_inj;
      end else if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
    end
  end

  // ---------------- bus monitor (activity counters) ----------------
  int aw_cyc = 0, w_cyc = 0, both_cyc = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_unstable = 0;
  logic              aw_prev = 1'b0;
  logic [ADDR_W-1:0] awaddr_prev = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if (m_axil_awvalid) aw_cyc++;
      if (m_axil_wvalid) w_cyc++;
      if (m_axil_awvalid && m_axil_wvalid) both_cyc++;
      if (m_axil_bvalid && m_axil_bready) b_hs++;
      if (m_axil_arvalid && m_axil_arready) ar_hs++;
      if (m_axil_rvalid && m_axil_rready) r_hs++;
      if (m_axil_awvalid && aw_prev && m_axil_awaddr != awaddr_prev) aw_unstable++;
    end
    aw_prev     <= m_axil_awvalid;
    awaddr_prev <= m_axil_awaddr;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [16];
  logic [34:0]       exp_q[$];
  logic [15:0]       exp_err = 16'h0000;
  int checks = 0, errors = 0;

  initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

  // Driver: issue one command, wait for its response, check payload, latency,
  // hold behaviour, back-to-back readiness and the error count.
  task automatic do_cmd(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [1:0] rs, input int hold, input int exp_lat);
    logic [34:0] exp, got, first;
    int n;
    if (we) begin
      for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
      exp = {1'b1, 32'h0, rs};
    end else begin
      exp = {1'b0, ref_mem[addr[5:2]], rs};
    end
    if (rs != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    exp_q.push_back(exp);
    b_inj = rs; r_inj = rs;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0; void'(exp_q.pop_front()); return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
      void'(exp_q.pop_front()); return;
    end
    if (exp_lat != 0) begin
      checks++;
      if (n !== exp_lat) begin errors++; $display("FAIL latency: got %0d cycles, required %0d", n, exp_lat); end
    end
    first = {rsp_we, rsp_rdata, rsp_resp};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_we, rsp_rdata, rsp_resp} !== first || cmd_ready !== 1'b0 ||
          (m_axil_awvalid | m_axil_wvalid | m_axil_arvalid | m_axil_bready | m_axil_rready) !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold: cycle %0d valid=%b payload=%h first=%h cmd_ready=%b aw=%b w=%b ar=%b b=%b r=%b, required stable/idle",
                 h, rsp_valid, {rsp_we, rsp_rdata, rsp_resp}, first, cmd_ready,
                 m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready);
      end
    end
    got = {rsp_we, rsp_rdata, rsp_resp};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rsp_payload: we/rdata/resp got %b/%h/%b, required %b/%h/%b",
               got[34], got[33:2], got[1:0], exp[34], exp[33:2], exp[1:0]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || err_count !== exp_err) begin
      errors++;
      $display("FAIL after_rsp: rsp_valid=%b cmd_ready=%b busy=%b err_count=%h, required 0/1/0/%h",
               rsp_valid, cmd_ready, busy, err_count, exp_err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, busy, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 8'h00 ||
        err_count !== 16'h0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || m_axil_awaddr !== '0 || m_axil_awprot !== 3'b000) begin
      errors++;
      $display("FAIL reset_values: ready=%b rsp_valid=%b busy=%b err=%h rdata=%h awaddr=%h, required all 0",
               cmd_ready, rsp_valid, busy, err_count, rsp_rdata, m_axil_awaddr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release: cmd_ready=%b, required 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_write_leds;
    int aw0, w0, both0, b0;
    aw0 = aw_cyc; w0 = w_cyc; both0 = both_cyc; b0 = b_hs;
    aw_delay = 0; w_delay = 0;
    do_cmd(1'b1, LEDS_ADDR, 32'h0000_00A5, 4'hF, 2'b00, 0, 3);
    checks++;
    if (aw_cyc - aw0 != 1 || w_cyc - w0 != 1 || both_cyc - both0 != 1 || b_hs - b0 != 1) begin
      errors++;
      $display("FAIL write_channels: aw=%0d w=%0d both=%0d b=%0d, required 1/1/1/1",
               aw_cyc - aw0, w_cyc - w0, both_cyc - both0, b_hs - b0);
    end
    checks++;
    if (slv_mem[LEDS_ADDR[5:2]][7:0] !== 8'hA5) begin
      errors++; $display("FAIL led_value: got %h, required a5", slv_mem[LEDS_ADDR[5:2]][7:0]);
    end
  endtask

  task automatic test_read_leds;
    int ar0, r0;
    ar0 = ar_hs; r0 = r_hs;
    do_cmd(1'b0, LEDS_ADDR, 32'hDEAD_BEEF, 4'h0, 2'b00, 0, 3);
    checks++;
    if (ar_hs - ar0 != 1 || r_hs - r0 != 1) begin
      errors++; $display("FAIL read_channels: ar=%0d r=%0d, required 1/1", ar_hs - ar0, r_hs - r0);
    end
  endtask

  task automatic test_aw_delay;
    int aw0, w0, b0, u0;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs; u0 = aw_unstable;
    aw_delay = 3; w_delay = 0;
    do_cmd(1'b1, 21'h000008, 32'h1234_5678, 4'hF, 2'b00, 0, 0);
    aw_delay = 0;
    checks++;
    if (aw_cyc - aw0 != 4 || w_cyc - w0 != 1 || b_hs - b0 != 1 || aw_unstable != u0) begin
      errors++;
      $display("FAIL aw_delay: aw=%0d w=%0d b=%0d unstable=%0d, required 4/1/1/0",
               aw_cyc - aw0, w_cyc - w0, b_hs - b0, aw_unstable - u0);
    end
  endtask

  task automatic test_err_resp;
    do_cmd(1'b1, 21'h00000C, 32'hCAFE_0001, 4'h3, 2'b10, 0, 3);
    do_cmd(1'b0, 21'h00000C, 32'h0, 4'h0, 2'b11, 0, 3);
    checks++;
    if (err_count !== 16'd2) begin errors++; $display("FAIL err_count_two: got %h, required 0002", err_count); end
  endtask

  task automatic test_rsp_backpressure;
    do_cmd(1'b0, 21'h000008, 32'h0, 4'h0, 2'b00, 5, 3);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      logic we; logic [3:0] ws; logic [1:0] rs; int hold;
      we = 1'($urandom_range(0, 1));
      ws = 4'($urandom_range(1, 15));
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hold = $urandom_range(0, 2);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      do_cmd(we, {15'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, ws, rs, hold,
             (aw_delay == 0 && w_delay == 0 && ar_delay == 0) ? 3 : 0);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0;
  endtask

  task automatic test_saturate;
    @(negedge clk);
    force dut.err_cnt = 16'hFFFE;
    #1 release dut.err_cnt;
    exp_err = 16'hFFFE;
    do_cmd(1'b1, 21'h000010, 32'h5555_AAAA, 4'hF, 2'b01, 0, 3);
    checks++;
    if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_reach_max: got %h, required ffff", err_count); end
    do_cmd(1'b0, 21'h000010, 32'h0, 4'h0, 2'b10, 0, 3);
    checks++;
    if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_saturate: got %h, required ffff", err_count); end
  endtask

  task automatic test_reset_mid_read;
    int n;
    ar_delay = 50;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = LEDS_ADDR;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_axil_arvalid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (m_axil_arvalid !== 1'b1) begin errors++; $display("FAIL arvalid_before_rst: got %b, required 1", m_axil_arvalid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_axil_arvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: arvalid=%b busy=%b cmd_ready=%b rsp_valid=%b, required 0/0/0/0",
               m_axil_arvalid, busy, cmd_ready, rsp_valid);
    end
    ar_delay = 0;
    exp_err = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || err_count !== 16'h0) begin
      errors++; $display("FAIL post_rst_release: cmd_ready=%b err=%h, required 0/0000", cmd_ready, err_count);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: cmd_ready=%b, required 1", cmd_ready); end
    do_cmd(1'b0, LEDS_ADDR, 32'h0, 4'h0, 2'b00, 0, 3);
  endtask

  initial begin
    test_reset();
    test_write_leds();
    test_read_leds();
    test_aw_delay();
    test_err_resp();
    test_rsp_backpressure();
    test_random();
    test_saturate();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
